alu_share_ctrl: RTL

- Two-requester scheduler for the shared 8-bit combinational posit ALU (ops: add, sub, and, or, xor, compare).
- Arbitrates requests round-robin, registers operands and op-select into the ALU, and captures result and compare flags one cycle later.
- Returns each result on a single tagged response channel and maintains the architectural C/Z flag register.

---
 rtl/alu_share_ctrl_if.sv | 65 ++++++
 rtl/alu_share_ctrl.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/alu_share_ctrl_if.sv
// -----------------------------------------------------------------------------
// alu_share_ctrl_if
// Bundles every non-clock/reset signal of the shared posit-ALU scheduler:
//   - two request channels (reqN_valid/ready/op/a/b)
//   - the tagged response channel (resp_valid/ready/id/data/err)
//   - the registered drive into the external combinational ALU and its result
//   - the architectural C/Z flag outputs
// Modports:
//   slave  : the scheduler (alu_share_ctrl)
//   master : the environment (requesters, response consumer, ALU)
// -----------------------------------------------------------------------------
interface alu_share_ctrl_if #(
  parameter int DATA_W = 8
);
  // requester 0
  logic              req0_valid;
  logic              req0_ready;
  logic [2:0]        req0_op;
  logic [DATA_W-1:0] req0_a;
  logic [DATA_W-1:0] req0_b;
  // requester 1
  logic              req1_valid;
  logic              req1_ready;
  logic [2:0]        req1_op;
  logic [DATA_W-1:0] req1_a;
  logic [DATA_W-1:0] req1_b;
  // response channel
  logic              resp_valid;
  logic              resp_ready;
  logic              resp_id;
  logic [DATA_W-1:0] resp_data;
  logic              resp_err;
  // ALU connection
  logic [DATA_W-1:0] alu_in1;
  logic [DATA_W-1:0] alu_in2;
  logic [2:0]        alu_sel;
  logic [DATA_W-1:0] alu_out;
  logic              alu_c;
  logic              alu_z;
  // architectural flags
  logic              flag_c;
  logic              flag_z;

  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b,
    input  req1_valid, req1_op, req1_a, req1_b,
    input  resp_ready,
    input  alu_out, alu_c, alu_z,
    output req0_ready, req1_ready,
    output resp_valid, resp_id, resp_data, resp_err,
    output alu_in1, alu_in2, alu_sel,
    output flag_c, flag_z
  );

  modport master (
    output req0_valid, req0_op, req0_a, req0_b,
    output req1_valid, req1_op, req1_a, req1_b,
    output resp_ready,
    output alu_out, alu_c, alu_z,
    input  req0_ready, req1_ready,
    input  resp_valid, resp_id, resp_data, resp_err,
    input  alu_in1, alu_in2, alu_sel,
    input  flag_c, flag_z
  );
endinterface

// File: rtl/alu_share_ctrl.sv
// -----------------------------------------------------------------------------
// alu_share_ctrl
// Two-requester scheduler in front of a shared combinational 8-bit posit ALU.
//   - Round-robin arbitration between requester 0 and 1 while idle.
//   - Registers op-select and operands into the ALU, captures the ALU result
//     (and compare flags) one cycle later, and returns it on a single tagged
//     response channel.
//   - Maintains the architectural C/Z flags, updated only by compare (op 101).
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   bus  : alu_share_ctrl_if.slave (requests, response, ALU drive, flags)
// Parameters:
//   DATA_W    : operand/result width (must match the ALU, >= 3)
//   FIRST_PRI : requester favoured on the first contended grant after reset
// -----------------------------------------------------------------------------
module alu_share_ctrl #(
  parameter int DATA_W    = 8,
  parameter bit FIRST_PRI = 1'b0
) (
  input  logic                clk,
  input  logic                rst,
  alu_share_ctrl_if.slave     bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam logic [2:0] OP_CMP = 3'b101;
  // AND keeps the ALU output well defined while nothing has been issued.
  localparam logic [2:0] OP_AND = 3'b010;
  // The pointer records the last grant; starting it at ~FIRST_PRI makes
  // FIRST_PRI win the first contended arbitration.
  localparam logic PTR_RST = FIRST_PRI ? 1'b0 : 1'b1;

  // Op-selects 110 and 111 have no ALU function.
  function automatic logic op_is_illegal(input logic [2:0] op);
    return op[2] & op[1];
  endfunction

  // Compare result packs {C, Z} into the two low bits of the response.
  function automatic logic [DATA_W-1:0] pack_flags(input logic c, input logic z);
    return {{(DATA_W-2){1'b0}}, c, z};
  endfunction

  state_t            r_state;
  logic              r_last_gnt;
  logic              r_resp_valid;
  logic              r_resp_id;
  logic [DATA_W-1:0] r_resp_data;
  logic              r_resp_err;
  logic [DATA_W-1:0] r_alu_in1;
  logic [DATA_W-1:0] r_alu_in2;
  logic [2:0]        r_alu_sel;
  logic              r_flag_c;
  logic              r_flag_z;

  logic              w_any_valid;
  logic              w_gnt_id;
  logic              w_accept;
  logic [2:0]        w_op;
  logic [DATA_W-1:0] w_a;
  logic [DATA_W-1:0] w_b;

  // Arbitration: pick the granted requester and mux its request fields.
  always_comb begin
    w_any_valid = bus.req0_valid | bus.req1_valid;
    if (bus.req0_valid && bus.req1_valid) begin
      // contention: the one not served last time wins
      w_gnt_id = ~r_last_gnt;
    end else if (bus.req1_valid) begin
      w_gnt_id = 1'b1;
    end else begin
      w_gnt_id = 1'b0;
    end
    w_accept = (r_state == S_IDLE) && w_any_valid;
    if (w_gnt_id) begin
      w_op = bus.req1_op;
      w_a  = bus.req1_a;
      w_b  = bus.req1_b;
    end else begin
      w_op = bus.req0_op;
      w_a  = bus.req0_a;
      w_b  = bus.req0_b;
    end
  end

  // Readys are the combinational grant, only ever offered in IDLE.
  assign bus.req0_ready = w_accept & ~w_gnt_id;
  assign bus.req1_ready = w_accept &  w_gnt_id;

  assign bus.resp_valid = r_resp_valid;
  assign bus.resp_id    = r_resp_id;
  assign bus.resp_data  = r_resp_data;
  assign bus.resp_err   = r_resp_err;
  assign bus.alu_in1    = r_alu_in1;
  assign bus.alu_in2    = r_alu_in2;
  assign bus.alu_sel    = r_alu_sel;
  assign bus.flag_c     = r_flag_c;
  assign bus.flag_z     = r_flag_z;

  // Scheduler FSM with all registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_last_gnt   <= PTR_RST;
      r_resp_valid <= 1'b0;
      r_resp_id    <= 1'b0;
      r_resp_data  <= '0;
      r_resp_err   <= 1'b0;
      r_alu_in1    <= '0;
      r_alu_in2    <= '0;
      r_alu_sel    <= OP_AND;
      r_flag_c     <= 1'b0;
      r_flag_z     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_last_gnt <= w_gnt_id;
            r_resp_id  <= w_gnt_id;
            if (op_is_illegal(w_op)) begin
              // ALU bypassed: alu_sel keeps its old value, error returned next cycle
              r_resp_valid <= 1'b1;
              r_resp_data  <= '0;
              r_resp_err   <= 1'b1;
              r_state      <= S_RESP;
            end else begin
              r_alu_sel <= w_op;
              r_alu_in1 <= w_a;
              r_alu_in2 <= w_b;
              r_state   <= S_EXEC;
            end
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_EXEC: begin
          r_resp_valid <= 1'b1;
          r_resp_err   <= 1'b0;
          if (r_alu_sel == OP_CMP) begin
            r_resp_data <= pack_flags(bus.alu_c, bus.alu_z);
            r_flag_c    <= bus.alu_c;
            r_flag_z    <= bus.alu_z;
          end else begin
            r_resp_data <= bus.alu_out;
          end
          r_state <= S_RESP;
        end
        S_RESP: begin
          // response fields hold until the consumer takes them
          if (bus.resp_ready) begin
            r_resp_valid <= 1'b0;
            r_state      <= S_IDLE;
          end else begin
            r_state <= S_RESP;
          end
        end
        default: begin
          r_resp_valid <= 1'b0;
          r_state      <= S_IDLE;
        end
      endcase
    end
  end

endmodule
